// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch and data stages.
// Data has fixed priority; a sticky err flags a memory that stops answering.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          idone,
  output logic          istall,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          ddone,
  output logic          dstall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mready,
  output logic          err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIBusy, StDBusy, StIResp, StDResp} state_e;

  state_e          state_q, state_d;
  logic            mreq_q, mwe_q;
  logic [AW-1:0]   maddr_q;
  logic [DW-1:0]   mwdata_q, irdata_q, drdata_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            busy, grant;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dreq)      state_d = StDBusy;
        else if (ireq) state_d = StIBusy;
      end
      StIBusy: if (mready) state_d = ireq ? StIResp : StIdle;
      StDBusy: if (mready) state_d = dreq ? StDResp : StIdle;
      StIResp, StDResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    idone  = (state_q == StIResp);
    ddone  = (state_q == StDResp);
    istall = ireq & ~idone;
    dstall = dreq & ~ddone;
    mreq   = mreq_q;
    mwe    = mwe_q;
    maddr  = maddr_q;
    mwdata = mwdata_q;
    irdata = irdata_q;
    drdata = drdata_q;
    err    = err_q;
  end

  // Memory handshake and read-data capture; aborted accesses drop their data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dreq) begin
            mreq_q   <= 1'b1;
            mwe_q    <= dwe;
            maddr_q  <= daddr;
            mwdata_q <= dwdata;
          end else if (ireq) begin
            mreq_q  <= 1'b1;
            mwe_q   <= 1'b0;
            maddr_q <= iaddr;
          end
        end
        StIBusy: begin
          if (mready) begin
            mreq_q <= 1'b0;
            mwe_q  <= 1'b0;
            if (ireq) irdata_q <= mrdata;
          end
        end
        StDBusy: begin
          if (mready) begin
            mreq_q <= 1'b0;
            mwe_q  <= 1'b0;
            if (dreq && !mwe_q) drdata_q <= mrdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == StIBusy) || (state_q == StDBusy);
  assign grant = (state_q == StIdle) && (dreq || ireq);

  // Wait counter saturates at TIMEOUT; err is sticky until reset
  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      cnt_d = '0;
    end else if (busy && !mready && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
    err_d = err_q | (busy && (cnt_d == CW'(TIMEOUT)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after a rising edge,
// outputs are checked 1ns later, well away from the next edge.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq, dreq, dwe, mready;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwdata, mrdata;
  logic [DW-1:0] irdata, drdata, mwdata;
  logic [AW-1:0] maddr;
  logic          idone, istall, ddone, dstall, mreq, mwe, err;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireq   (ireq),
    .iaddr  (iaddr),
    .irdata (irdata),
    .idone  (idone),
    .istall (istall),
    .dreq   (dreq),
    .dwe    (dwe),
    .daddr  (daddr),
    .dwdata (dwdata),
    .drdata (drdata),
    .ddone  (ddone),
    .dstall (dstall),
    .mreq   (mreq),
    .mwe    (mwe),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mrdata (mrdata),
    .mready (mready),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (start of next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ireq = 0; dreq = 0; dwe = 0; mready = 0;
    iaddr = '0; daddr = '0; dwdata = '0; mrdata = '0;
    #12;
    check("rst_mreq", mreq, 0);
    check("rst_maddr", maddr, 0);
    check("rst_irdata", irdata, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // Fetch-only read, zero wait
    ireq = 1; iaddr = 32'h40; #1;
    check("f_c0_istall", istall, 1);
    check("f_c0_mreq", mreq, 0);
    tick();
    mready = 1; mrdata = 32'h8C020004; #1;
    check("f_c1_mreq", mreq, 1);
    check("f_c1_maddr", maddr, 32'h40);
    check("f_c1_mwe", mwe, 0);
    check("f_c1_istall", istall, 1);
    tick();
    mready = 0; #1;
    check("f_c2_idone", idone, 1);
    check("f_c2_irdata", irdata, 32'h8C020004);
    check("f_c2_istall", istall, 0);
    check("f_c2_mreq", mreq, 0);
    tick();
    ireq = 0; #1;
    check("f_c3_idone", idone, 0);
    tick();

    // Contention: store wins, then fetch; memory always ready
    ireq = 1; iaddr = 32'h44; dreq = 1; dwe = 1; daddr = 32'h100; dwdata = 32'hDEADBEEF;
    mready = 1; mrdata = 32'hAAAA5555; #1;
    tick();
    #1;
    check("c_c1_mreq", mreq, 1);
    check("c_c1_mwe", mwe, 1);
    check("c_c1_maddr", maddr, 32'h100);
    check("c_c1_mwdata", mwdata, 32'hDEADBEEF);
    check("c_c1_istall", istall, 1);
    tick();
    #1;
    check("c_c2_ddone", ddone, 1);
    check("c_c2_dstall", dstall, 0);
    check("c_c2_istall", istall, 1);
    check("c_c2_drdata", drdata, 0);
    tick();
    dreq = 0; dwe = 0; #1;
    check("c_c3_mreq", mreq, 0);
    check("c_c3_istall", istall, 1);
    tick();
    #1;
    check("c_c4_maddr", maddr, 32'h44);
    check("c_c4_mwe", mwe, 0);
    check("c_c4_idone", idone, 0);
    tick();
    #1;
    check("c_c5_idone", idone, 1);
    check("c_c5_irdata", irdata, 32'hAAAA5555);
    check("c_c5_drdata", drdata, 0);
    tick();
    ireq = 0; mready = 0;
    tick();

    // Load with 4 wait cycles
    dreq = 1; dwe = 0; daddr = 32'h200; dwdata = 32'h0BAD0BAD;
    for (int i = 1; i <= 4; i++) begin
      tick();
      #1;
      check("w_busy_maddr", maddr, 32'h200);
      check("w_busy_mreq", mreq, 1);
      check("w_busy_dstall", dstall, 1);
    end
    tick();
    mready = 1; mrdata = 32'h12345678; #1;
    check("w_c5_maddr", maddr, 32'h200);
    tick();
    mready = 0; #1;
    check("w_c6_ddone", ddone, 1);
    check("w_c6_drdata", drdata, 32'h12345678);
    tick();
    dreq = 0;
    tick();

    // Fetch abort
    ireq = 1; iaddr = 32'h80;
    tick();
    ireq = 0; #1;
    check("a_c1_mreq", mreq, 1);
    tick();
    mready = 1; mrdata = 32'hFFFF0000;
    tick();
    mready = 0; #1;
    check("a_c3_idone", idone, 0);
    check("a_c3_mreq", mreq, 0);
    check("a_c3_irdata", irdata, 32'hAAAA5555);
    ireq = 1; iaddr = 32'h84;
    tick();
    #1;
    check("a_c4_regrant", mreq, 1);
    check("a_c4_maddr", maddr, 32'h84);
    mready = 1; mrdata = 32'h11112222;
    tick();
    mready = 0; #1;
    check("a_c5_idone", idone, 1);
    check("a_c5_irdata", irdata, 32'h11112222);
    tick();
    ireq = 0;
    tick();

    // Timeout: 8 busy cycles with no mready
    ireq = 1; iaddr = 32'h90;
    for (int c = 1; c <= 8; c++) begin
      tick();
      #1;
      check("t_busy_err", err, 0);
    end
    tick();
    #1;
    check("t_c9_err", err, 1);
    check("t_c9_mreq", mreq, 1);
    tick();
    mready = 1; mrdata = 32'h33334444; #1;
    check("t_c10_err", err, 1);
    tick();
    mready = 0; #1;
    check("t_c11_idone", idone, 1);
    check("t_c11_irdata", irdata, 32'h33334444);
    check("t_c11_err", err, 1);
    tick();
    ireq = 0;
    tick();

    // Reset in the middle of a store
    dreq = 1; dwe = 1; daddr = 32'h300; dwdata = 32'hCAFEF00D;
    tick();
    #1;
    check("r_busy_mreq", mreq, 1);
    #1;
    reset = 1'b1;
    #1;
    check("r_mreq", mreq, 0);
    check("r_mwe", mwe, 0);
    check("r_maddr", maddr, 0);
    check("r_mwdata", mwdata, 0);
    check("r_irdata", irdata, 0);
    check("r_drdata", drdata, 0);
    check("r_err", err, 0);
    check("r_ddone", ddone, 0);
    reset = 1'b0; dreq = 0; dwe = 0;
    ireq = 1; iaddr = 32'h48; mready = 1; mrdata = 32'h55556666;
    tick();
    #1;
    check("r_f_maddr", maddr, 32'h48);
    check("r_f_mreq", mreq, 1);
    tick();
    #1;
    check("r_f_idone", idone, 1);
    check("r_f_irdata", irdata, 32'h55556666);
    ireq = 0; mready = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
